// File: rtl/mux_stream_rr.sv
// Registered N-channel stream mux with valid/ready handshake; fixed-select or round-robin arbitration.
// Define MUX_STREAM_PARITY_EN to add a registered even-parity output alongside out_data.
module mux_stream_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
`ifdef MUX_STREAM_PARITY_EN
    input  logic                    out_ready,
    output logic                    out_parity
`else
    input  logic                    out_ready
`endif
);

    localparam logic [SEL_W:0]   NCH    = NUM_CH[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_ch;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic               w_load;
    logic               w_found;
    logic [SEL_W-1:0]   w_gidx;
    logic [NUM_CH-1:0]  w_grant;
    logic               w_xfer;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0]   w_sel_data;

    // The register may take a new word when empty or while its held word drains.
    assign w_load = (r_state == S_EMPTY) | out_ready;

    always_comb begin
        logic [SEL_W:0] idx;
        w_found = 1'b0;
        w_gidx  = '0;
        idx     = '0;
        if (!mode) begin
            // Out-of-range sel matches no channel, so nothing is granted.
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    w_found = 1'b1;
                    w_gidx  = SEL_W'(k);
                end
            end
        end else begin
            // Scan downward so the smallest offset from rr_ptr overwrites last and wins.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
                if (idx >= NCH) idx = idx - NCH;
                if (in_valid[idx[SEL_W-1:0]]) begin
                    w_found = 1'b1;
                    w_gidx  = idx[SEL_W-1:0];
                end
            end
        end
    end

    assign w_grant    = w_found ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_gidx) : '0;
    assign in_ready   = w_grant & {NUM_CH{w_load & rst_n}};
    assign w_xfer     = |in_ready;
    assign w_ptr_nxt  = (w_gidx == LAST_CH) ? '0 : w_gidx + 1'b1;
    assign w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer) w_state_nxt = S_FULL;
            S_FULL:  if (out_ready && !w_xfer) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_data <= w_sel_data;
            r_ch   <= w_gidx;
            if (mode) r_rr_ptr <= w_ptr_nxt;
        end
    end

`ifdef MUX_STREAM_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_xfer) begin
            r_parity <= ^w_sel_data;
        end
    end

    assign out_parity = r_parity;
`endif

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = (r_state == S_FULL);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
    a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: directed scenarios plus randomized traffic vs a cycle model.
module tb_mux_stream_rr;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_STREAM_PARITY_EN
    logic           out_parity;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: held word and round-robin pointer.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;

    mux_stream_rr #(.WIDTH(W), .NUM_CH(N), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid),
`ifdef MUX_STREAM_PARITY_EN
        .out_ready(out_ready), .out_parity(out_parity)
`else
        .out_ready(out_ready)
`endif
    );

    always #5 clk = ~clk;

    function automatic int pick(bit md, int s, bit [N-1:0] v, int ptr);
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    endtask

    task automatic set_data(bit [7:0] d0, bit [7:0] d1, bit [7:0] d2, bit [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    // Called just after a falling edge; checks combinational ready and registered outputs,
    // then advances one clock and updates the model.
    task automatic step(string tag);
        int       g;
        bit       load;
        bit [N-1:0] er;
        bit [7:0] d;
        #1;
        load = !m_valid || out_ready;
        g = pick(mode, int'(sel), in_valid, m_ptr);
        er = (load && g >= 0) ? (N'(1) << g) : '0;
        n_chk++;
        if (in_ready !== er) begin
            n_fail++; $display("FAIL %s in_ready got %b want %b", tag, in_ready, er);
        end
        n_chk++;
        if (out_valid !== m_valid) begin
            n_fail++; $display("FAIL %s out_valid got %b want %b", tag, out_valid, m_valid);
        end
        n_chk++;
        if (out_data !== m_data || out_ch !== 2'(m_ch)) begin
            n_fail++; $display("FAIL %s out got %h/ch%0d want %h/ch%0d", tag, out_data, out_ch, m_data, m_ch);
        end
`ifdef MUX_STREAM_PARITY_EN
        n_chk++;
        if (out_parity !== ^m_data) begin
            n_fail++; $display("FAIL %s parity got %b want %b", tag, out_parity, ^m_data);
        end
`endif
        @(posedge clk);
        if (load && g >= 0) begin
            d = in_data[g*W +: W];
            m_valid = 1; m_data = d; m_ch = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '1; mode = 0; sel = 0; out_ready = 1;
        set_data(8'h55, 8'h0F, 8'hF0, 8'h7F);
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset got v=%b d=%h ch=%0d rdy=%b want 0/00/0/0000", out_valid, out_data, out_ch, in_ready);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        bit [7:0] exp_d [4] = '{8'h55, 8'h0F, 8'hF0, 8'h7F};
        int order [4] = '{2, 0, 1, 3};
        mode = 0; out_ready = 1; in_valid = '1;
        set_data(8'h55, 8'h0F, 8'hF0, 8'h7F);
        foreach (order[j]) begin
            sel = 2'(order[j]);
            #1;
            n_chk++;
            if (in_ready !== (4'b0001 << order[j])) begin
                n_fail++; $display("FAIL fixed_ready sel=%0d got %b", order[j], in_ready);
            end
            step("fixed");
            n_chk++;
            if (out_data !== exp_d[order[j]] || out_ch !== 2'(order[j]) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fixed_out sel=%0d got %h/ch%0d want %h", order[j], out_data, out_ch, exp_d[order[j]]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1; out_ready = 1; in_valid = '1;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        for (int c = 0; c < 8; c++) begin
            step("rr");
            n_chk++;
            if (out_ch !== 2'(c % N) || out_data !== 8'(8'h11 * (c % N + 1))) begin
                n_fail++; $display("FAIL rr_seq cycle %0d got ch%0d/%h want ch%0d", c, out_ch, out_data, c % N);
            end
        end
    endtask

    task automatic test_rr_skip();
        do_reset();
        mode = 1; out_ready = 1;
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        in_valid = 4'b0100; step("rr_to3");
        in_valid = 4'b0010; step("rr_skip");
        n_chk++;
        if (out_ch !== 2'd1 || m_ptr != 2) begin
            n_fail++; $display("FAIL rr_skip got ch%0d want ch1 (model ptr %0d)", out_ch, m_ptr);
        end
        in_valid = 4'b1001; step("rr_wrap");
        n_chk++;
        if (out_ch !== 2'd3 || out_data !== 8'hA3) begin
            n_fail++; $display("FAIL rr_wrap got ch%0d/%h want ch3/a3", out_ch, out_data);
        end
        in_valid = 4'b0000; step("rr_idle");
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 0; sel = 1; out_ready = 1; in_valid = 4'b0010;
        set_data(8'h01, 8'h0F, 8'h02, 8'h03);
        step("bp_load");
        out_ready = 0; in_valid = '1;
        set_data(8'h10, 8'h99, 8'h20, 8'h30);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++;
            if (in_ready !== 4'b0000 || out_data !== 8'h0F || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got rdy=%b d=%h v=%b want 0000/0f/1", c, in_ready, out_data, out_valid);
            end
            step("bp");
        end
        out_ready = 1; set_data(8'h10, 8'hA5, 8'h20, 8'h30);
        step("bp_release");
        n_chk++;
        if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_reload got %h v=%b want a5/1", out_data, out_valid);
        end
        in_valid = '0; step("bp_drain");
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            n_fail++; $display("FAIL bp_drain got v=%b d=%h want 0/a5", out_valid, out_data);
        end
    endtask

    task automatic test_async_reset();
        mode = 1; out_ready = 0; in_valid = '1;
        set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        step("ar_load");
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset got v=%b d=%h rdy=%b want 0/00/0000", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        in_valid = '0; step("ar_after");
    endtask

`ifdef MUX_STREAM_PARITY_EN
    task automatic test_parity();
        mode = 0; sel = 0; out_ready = 1; in_valid = 4'b0001;
        set_data(8'h07, 8'h00, 8'h00, 8'h00); step("par07");
        n_chk++;
        if (out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_07 got %b want 1", out_parity); end
        set_data(8'h0F, 8'h00, 8'h00, 8'h00); step("par0f");
        n_chk++;
        if (out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_0f got %b want 0", out_parity); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 16 == 0) mode = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step("random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fixed();
        test_round_robin();
        test_rr_skip();
        test_backpressure();
        test_async_reset();
`ifdef MUX_STREAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
